// File: rtl/dcache_controller.sv
`timescale 1ns/1ps
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between the CPU
//   memory stage and a block-wide (128-bit) main memory.
//
//   Ports
//     CLK, RESET          clock and asynchronous active-low reset
//     READ, WRITE         load / store request (both high counts as a store)
//     FUNCT3              access width and sign (B, H, W, BU, HU)
//     ADDRESS, WRITEDATA  byte address and store data
//     READDATA            sign- or zero-extended load result (combinational)
//     BUSYWAIT            pipeline stall request
//     MEM_READ/MEM_WRITE  block transfer strobes toward main memory
//     MEM_ADDRESS         block address (byte address >> 4)
//     MEM_WRITEDATA       victim block during a writeback
//     MEM_READDATA        fill block
//     MEM_BUSYWAIT        memory busy; a transfer completes on an edge where it is low
//
//   Optional feature: define DCACHE_STATS_EN to add the saturating
//   HIT_COUNT / MISS_COUNT outputs.
module dcache_controller #(
  parameter int LINES = 8,
  parameter int TAG_W = 25
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [2:0]   FUNCT3,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int INDEX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;

  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [LINES-1:0]       dirty_q, dirty_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [27:0]            mem_addr_q, mem_addr_d;

  logic [127:0]           data_q [LINES];
  logic [TAG_W-1:0]       tag_q  [LINES];

  logic [INDEX_W-1:0]     line_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [127:0]           line_data;
  logic [TAG_W-1:0]       line_tag;
  logic                   req, hit;
  logic                   data_we, tag_we;
  logic [127:0]           data_wdata, merged;
  logic [31:0]            ld_word, load_ext;
  logic [15:0]            ld_half;
  logic [7:0]             ld_byte;

  assign line_idx  = ADDRESS[4 +: INDEX_W];
  assign req_tag   = ADDRESS[31 -: TAG_W];
  assign line_data = data_q[line_idx];
  assign line_tag  = tag_q[line_idx];
  assign req       = READ | WRITE;
  assign hit       = valid_q[line_idx] && (line_tag == req_tag);

  // Store merge: SH ignores ADDRESS[0], SW ignores ADDRESS[1:0].
  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    merged = line_data;
    case (FUNCT3[1:0])
      2'b00:   merged[{ADDRESS[3:0], 3'b000}  +: 8]  = WRITEDATA[7:0];
      2'b01:   merged[{ADDRESS[3:1], 4'b0000} +: 16] = WRITEDATA[15:0];
      default: merged[{ADDRESS[3:2], 5'b00000} +: 32] = WRITEDATA;
    endcase
  end

  // Load path: select word, then half/byte, then extend.
  assign ld_word = line_data[{ADDRESS[3:2], 5'b00000} +: 32];
  assign ld_half = ld_word[{ADDRESS[1], 4'b0000} +: 16];
  assign ld_byte = ld_word[{ADDRESS[1:0], 3'b000} +: 8];

  always_comb begin
    load_ext = ld_word;
    case (FUNCT3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = ld_word;
    endcase
  end

  // Next-state and line-update logic.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    data_wdata = merged;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (WRITE) begin
              data_we           = 1'b1;
              dirty_d[line_idx] = 1'b1;
            end
          end else if (valid_q[line_idx] && dirty_q[line_idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: if (!MEM_BUSYWAIT) state_d = ALLOCATE;
      ALLOCATE:  if (!MEM_BUSYWAIT) state_d = REFILL;
      REFILL: begin
        data_we           = 1'b1;
        tag_we            = 1'b1;
        data_wdata        = MEM_READDATA;
        valid_d[line_idx] = 1'b1;
        dirty_d[line_idx] = 1'b0;
        state_d           = IDLE;
      end
    endcase
  end

  // Memory-side outputs are registered against the state being entered, so
  // they are stable for the whole transfer and clear with the async reset.
  always_comb begin
    mem_read_d  = (state_d == ALLOCATE);
    mem_write_d = (state_d == WRITEBACK);
    mem_addr_d  = '0;
    if (state_d == WRITEBACK)     mem_addr_d = {line_tag, line_idx};
    else if (state_d == ALLOCATE) mem_addr_d = ADDRESS[31:4];
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // NOTE: the tag and data arrays are plain storage with no reset; the valid bits alone decide whether a line holds anything.
  always_ff @(posedge CLK) begin
    if (data_we) data_q[line_idx] <= data_wdata;
    if (tag_we)  tag_q[line_idx]  <= req_tag;
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  // The indexed line cannot change during a writeback, so the victim is read straight out.
  assign MEM_WRITEDATA = mem_write_q ? line_data : '0;

  // Both outputs are forced quiet while reset is held.
  assign BUSYWAIT = RESET && ((state_q != IDLE) || (req && !hit));
  assign READDATA = (RESET && state_q == IDLE && READ && !WRITE && hit) ? load_ext : 32'd0;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        prev_refill_q;

  // The hit that follows a refill is the same access re-evaluating, not a new hit.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && req && hit && !prev_refill_q && hit_count_q != 32'hFFFF_FFFF)
      hit_count_d = hit_count_q + 32'd1;
    if (state_q == IDLE && state_d != IDLE && miss_count_q != 32'hFFFF_FFFF)
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      prev_refill_q <= 1'b0;
    end else begin
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      prev_refill_q <= (state_q == REFILL);
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
`timescale 1ns/1ps
// tb_dcache_controller
//   Scoreboard bench: each access runs through a behavioural cache model that
//   queues the expected load value and the expected memory transfers; one
//   monitor pops loads, the memory model pops transfers as they complete.
module tb_dcache_controller;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         READ = 1'b0, WRITE = 1'b0;
  logic [2:0]   FUNCT3 = 3'd0;
  logic [31:0]  ADDRESS = 32'd0, WRITEDATA = 32'd0;
  logic [31:0]  READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA = 128'd0;
  logic         MEM_BUSYWAIT = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } xfer_t;

  int checks = 0;
  int errors = 0;
  int mem_lat = 2;
  int mem_cnt = 0;

  logic [31:0]  ld_q[$];
  xfer_t        exp_xfer_q[$];
  logic [127:0] mem_q   [logic [27:0]];   // actual main memory
  logic [127:0] exp_mem [logic [27:0]];   // model's view of main memory

  // Reference cache: what the CPU should observe, no timing or FSM.
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];
  logic [24:0]  tags    [4] = '{25'd0, 25'd1, 25'd2, 25'h1FF_FFFF};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] init_block(input logic [27:0] b);
    logic [127:0] v;
    if (b == 28'h4) return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 4; i++)
      v[32*i +: 32] = (32'(b) * 32'h9E3779B1) ^ (32'(i) * 32'h01234567) ^ 32'h8080_0080;
    return v;
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] b);
    return mem_q.exists(b) ? mem_q[b] : init_block(b);
  endfunction

  function automatic logic [127:0] exp_get(input logic [27:0] b);
    return exp_mem.exists(b) ? exp_mem[b] : init_block(b);
  endfunction

  function automatic logic [7:0] mbyte(input int idx, input int o);
    return m_data[idx][o*8 +: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic [31:0] addr, input bit st, input logic [2:0] f3,
                              input logic [31:0] wd, output int stall, output logic [31:0] rd);
    int          idx, o;
    logic [24:0] tg;
    logic [15:0] h;
    xfer_t       x;
    idx = int'(addr[6:4]);
    tg  = addr[31:7];
    o   = int'(addr[3:0]);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      stall = 0;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        x.wr = 1'b1; x.addr = {m_tag[idx], 3'(idx)}; x.data = m_data[idx];
        exp_xfer_q.push_back(x);
        exp_mem[x.addr] = m_data[idx];
        stall = 2 * mem_lat + 4;
      end else begin
        stall = mem_lat + 3;
      end
      x.wr = 1'b0; x.addr = addr[31:4]; x.data = 128'd0;
      exp_xfer_q.push_back(x);
      m_data[idx]  = exp_get(addr[31:4]);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    rd = 32'd0;
    if (st) begin
      case (f3)
        3'd0: m_data[idx][o*8 +: 8] = wd[7:0];
        3'd1: for (int k = 0; k < 2; k++) m_data[idx][((o & ~1) + k)*8 +: 8] = wd[8*k +: 8];
        default: for (int k = 0; k < 4; k++) m_data[idx][((o & ~3) + k)*8 +: 8] = wd[8*k +: 8];
      endcase
      m_dirty[idx] = 1'b1;
    end else begin
      case (f3)
        3'd0: rd = 32'(signed'(mbyte(idx, o)));
        3'd4: rd = {24'd0, mbyte(idx, o)};
        3'd1, 3'd5: begin
          h  = {mbyte(idx, (o & ~1) + 1), mbyte(idx, o & ~1)};
          rd = (f3 == 3'd1) ? 32'(signed'(h)) : {16'd0, h};
        end
        default: rd = {mbyte(idx, (o & ~3) + 3), mbyte(idx, (o & ~3) + 2),
                       mbyte(idx, (o & ~3) + 1), mbyte(idx, o & ~3)};
      endcase
    end
  endtask

  // One CPU access, issued just after a rising edge; returns just after the edge that ends it.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_lit, input logic [31:0] lit);
    int          exp_stall, busy;
    logic [31:0] mrd;
    model_access(addr, wr, f3, wd, exp_stall, mrd);
    if (rd && !wr) ld_q.push_back(use_lit ? lit : mrd);
    READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITEDATA = wd;
    busy = 0;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT || busy > 200) break;
      busy++;
    end
    check("stall_cycles", 128'(busy), 128'(exp_stall));
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic idle_cycle();
    READ = 1'b0; WRITE = 1'b0; ADDRESS = $urandom;
    @(negedge CLK);
    check("idle_outputs", {BUSYWAIT, READDATA}, 128'd0);
    @(posedge CLK); #1;
  endtask

  // Load monitor: one pop per load cycle in which the cache does not stall.
  initial forever begin
    @(negedge CLK);
    if (RESET && READ && !WRITE && !BUSYWAIT) begin
      check("load_expected", 128'(ld_q.size() != 0), 128'd1);
      if (ld_q.size() != 0) check("load_data", READDATA, ld_q.pop_front());
    end
  end

  // Main memory: stalls mem_lat cycles per transfer, then completes.
  initial forever begin
    @(negedge CLK);
    if (MEM_READ || MEM_WRITE) begin
      check("mem_strobe_excl", 128'(MEM_READ & MEM_WRITE), 128'd0);
      if (mem_cnt < mem_lat) begin
        MEM_BUSYWAIT = 1'b1;
        mem_cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        mem_cnt = 0;
        check("xfer_expected", 128'(exp_xfer_q.size() != 0), 128'd1);
        if (exp_xfer_q.size() != 0) begin
          xfer_t x;
          x = exp_xfer_q.pop_front();
          check("xfer_kind", 128'(MEM_WRITE), 128'(x.wr));
          check("xfer_addr", 128'(MEM_ADDRESS), 128'(x.addr));
          if (x.wr) check("wb_data", MEM_WRITEDATA, x.data);
        end
        if (MEM_WRITE) mem_q[MEM_ADDRESS] = MEM_WRITEDATA;
        else           MEM_READDATA = mem_get(MEM_ADDRESS);
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
      mem_cnt = 0;
      if (RESET && !BUSYWAIT) check("idle_mem_bus", {MEM_ADDRESS, MEM_WRITEDATA}, 128'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int          wcnt;
    logic [31:0] a;
    logic [2:0]  f;
    model_reset();

    // Reset with a request pending: outputs quiet.
    READ = 1'b1; ADDRESS = 32'h40; FUNCT3 = 3'b010;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busywait", 128'(BUSYWAIT), 128'd0);
    check("rst_readdata", 128'(READDATA), 128'd0);
    check("rst_mem_strobes", 128'({MEM_READ, MEM_WRITE}), 128'd0);
    READ = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;

    // 1: clean miss then fill.
    mem_lat = 2;
    do_op(1, 0, 3'b010, 32'h40, 0, 1, 32'h11111111);

    // 2: byte store and loads on a hit.
    do_op(0, 1, 3'b000, 32'h41, 32'h000000FF, 0, 0);
    do_op(1, 0, 3'b000, 32'h41, 0, 1, 32'hFFFFFFFF);
    do_op(1, 0, 3'b100, 32'h41, 0, 1, 32'h000000FF);
    do_op(1, 0, 3'b101, 32'h40, 0, 1, 32'h0000FF11);

    // 3: conflicting miss on a dirty line, 5-cycle memory stalls.
    mem_lat = 5;
    do_op(1, 0, 3'b010, 32'h440, 0, 0, 0);

    // 4: halfword stores and signed/unsigned halfword loads.
    mem_lat = 1;
    do_op(0, 1, 3'b001, 32'h46, 32'h00001234, 0, 0);
    do_op(1, 0, 3'b001, 32'h46, 0, 1, 32'h00001234);
    do_op(0, 1, 3'b001, 32'h47, 32'h0000F000, 0, 0);
    do_op(1, 0, 3'b001, 32'h46, 0, 1, 32'hFFFFF000);
    do_op(1, 0, 3'b010, 32'h44, 0, 1, 32'hF0002222);

    // 5: reset in the middle of a writeback.
    mem_lat = 5;
    READ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h440;
    wcnt = 0;
    do begin
      @(negedge CLK);
      wcnt++;
    end while (!MEM_WRITE && wcnt < 20);
    check("wb_started", 128'(MEM_WRITE), 128'd1);
    RESET = 1'b0;
    #1;
    check("rst_drops_mem_write", 128'({MEM_READ, MEM_WRITE}), 128'd0);
    check("rst_mid_busywait", 128'(BUSYWAIT), 128'd0);
    check("rst_mid_readdata", 128'(READDATA), 128'd0);
    exp_xfer_q.delete();
    model_reset();
    READ = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    mem_lat = 2;
    do_op(1, 0, 3'b001, 32'h46, 0, 1, 32'h00002222);

    // Randomized traffic over a few conflicting tags.
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind    = $urandom_range(0, 9);
      mem_lat = $urandom_range(0, 3);
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      if (kind < 5) begin
        f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7))
                                        : 3'($urandom_range(0, 5));
        if (f == 3'd2 && $urandom_range(0, 3) == 0) f = 3'd3;
        do_op(1, 0, f, a, 0, 0, 0);
      end else if (kind < 8) begin
        do_op(0, 1, 3'($urandom_range(0, 2)), a, $urandom, 0, 0);
      end else if (kind == 8) begin
        do_op(1, 1, 3'($urandom_range(0, 2)), a, $urandom, 0, 0);
      end else begin
        idle_cycle();
      end
    end

`ifdef DCACHE_STATS_EN
    // 6: miss, hit, hit, dirty miss.
    RESET = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    mem_lat = 1;
    do_op(1, 0, 3'b010, 32'h40, 0, 0, 0);
    do_op(0, 1, 3'b010, 32'h44, 32'hCAFEF00D, 0, 0);
    do_op(1, 0, 3'b010, 32'h44, 0, 1, 32'hCAFEF00D);
    do_op(1, 0, 3'b010, 32'h440, 0, 0, 0);
    check("miss_count", 128'(MISS_COUNT), 128'd2);
    check("hit_count", 128'(HIT_COUNT), 128'd2);
`endif

    repeat (2) @(posedge CLK);
    check("load_q_drained", 128'(ld_q.size()), 128'd0);
    check("xfer_q_drained", 128'(exp_xfer_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and a block-wide main memory.
- Consumes the EX/MEM outputs: MEMREAD, MEMWRITE, FUNCT3, ALU result as address, and store data.
- Returns load data plus BUSYWAIT. The pipeline stalls while BUSYWAIT is high.
- Handles the RV32IM load/store widths (B/H/W, signed and unsigned).

Parameters:
- LINES, 8, number of cache lines; power of two. INDEX_W = log2(LINES).
- TAG_W, 25, tag width = 32 - 4 - INDEX_W; must equal 28 - INDEX_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  load request from the memory stage.
- WRITE  in  1  store request from the memory stage.
- FUNCT3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDRESS  in  32  byte address; [3:0] offset, [3+INDEX_W:4] index, [31:4+INDEX_W] tag.
- WRITEDATA  in  32  store data; low bits used for SB/SH.
- READDATA  out  32  load result; sign- or zero-extended.
- BUSYWAIT  out  1  stall request to the pipeline.
- MEM_READ  out  1  block read strobe to main memory.
- MEM_WRITE  out  1  block write strobe to main memory.
- MEM_ADDRESS  out  28  block address (byte address >> 4).
- MEM_WRITEDATA  out  128  victim block.
- MEM_READDATA  in  128  fill block.
- MEM_BUSYWAIT  in  1  main memory busy; a transfer completes on the edge where it is low.

Behaviour:
- Storage per line: valid, dirty, tag, 128-bit data (4 words, little-endian bytes).
- Hit = valid[index] && tag match.
- Request = READ | WRITE. If both are high, the cache treats the access as a WRITE.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL.

IDLE:
- Read hit: READDATA is combinational from the line; BUSYWAIT = 0; zero added latency.
- Write hit: BUSYWAIT = 0.
  - Bytes are merged at the rising edge: SB uses ADDRESS[3:0]; SH uses ADDRESS[3:1] with ADDRESS[0] ignored; SW uses ADDRESS[3:2] with ADDRESS[1:0] ignored.
  - The line's dirty bit is set.
- Miss: BUSYWAIT = 1 combinationally in the same cycle. Next state is WRITEBACK if valid && dirty, else ALLOCATE.
- No request: BUSYWAIT = 0; READDATA = 0.

WRITEBACK:
- MEM_WRITE = 1; MEM_ADDRESS = {old tag, index}; MEM_WRITEDATA = line data.
- Outputs are held stable while MEM_BUSYWAIT = 1.
- On an edge with MEM_BUSYWAIT = 0, go to ALLOCATE. BUSYWAIT = 1 throughout.

ALLOCATE:
- MEM_READ = 1; MEM_ADDRESS = ADDRESS[31:4].
- On an edge with MEM_BUSYWAIT = 0, go to REFILL. BUSYWAIT = 1.

REFILL (one cycle):
- Line data <= MEM_READDATA; tag updated; valid = 1; dirty = 0.
- BUSYWAIT = 1. Next state is IDLE, where the access re-evaluates as a hit.
- Total miss penalty is therefore memory latency + 2 cycles (clean) or 2x memory latency + 2 cycles (dirty).

Load extension:
- B: sign-extended from bit 7. BU: zero-extended.
- H: sign-extended from bit 15. HU: zero-extended.
- Any other FUNCT3 is treated as W.

Outside IDLE:
- MEM_READ and MEM_WRITE are never both 1.
- In IDLE both are 0, MEM_ADDRESS = 0 and MEM_WRITEDATA = 0.

The request must stay stable while BUSYWAIT = 1. The pipeline guarantees this; the cache does not latch it.

RESET low (asynchronous, including mid-transfer):
- All valid and dirty bits clear; state returns to IDLE.
- MEM_READ and MEM_WRITE drop to 0 immediately.
- Data array contents are don't-care; READDATA = 0.
- BUSYWAIT = 0 while RESET is held low.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0], both cleared by RESET.
  - MISS_COUNT increments on the IDLE->WRITEBACK or IDLE->ALLOCATE transition.
  - HIT_COUNT increments on an edge in IDLE with a request, a hit, and the previous state not REFILL, so a refill is not double-counted.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then LW 0x00000040 (memory block 0x4 = {0x44444444, 0x33333333, 0x22222222, 0x11111111}) -> BUSYWAIT high, MEM_READ with MEM_ADDRESS 0x0000004, no MEM_WRITE. After the fill, READDATA = 0x11111111 and BUSYWAIT falls.
2. SB 0x000000FF to 0x41, then LB 0x41 -> no stall on either; READDATA = 0xFFFFFFFF. LBU 0x41 -> 0x000000FF. LHU 0x40 -> 0x0000FF11.
3. LW 0x00000440 (same index 4, different tag) after test 2 -> MEM_WRITE of the dirty block to MEM_ADDRESS 0x0000004 with byte 1 = 0xFF. Then MEM_READ of 0x0000044. BUSYWAIT held throughout with MEM_BUSYWAIT stalled 5 cycles per transfer.
4. SH 0x00001234 to 0x46 -> halfword lands at bytes 6..7. LH 0x46 -> 0x00001234. SH 0x0000F000 to 0x46, then LH 0x46 -> 0xFFFFF000.
5. Assert RESET low during WRITEBACK -> MEM_WRITE drops that instant. After release, a previously hit address now misses with a clean allocate (no writeback).
6. With DCACHE_STATS_EN: the sequence miss, hit, hit, dirty miss -> MISS_COUNT = 2, HIT_COUNT = 2.
